// File: rtl/forward_ctrl_pkg.sv
// forward_ctrl_pkg
//   Shared definitions for the EX-stage forwarding / load-use hazard logic.
//   - FWD_* : operand mux select codes, also used by the datapath muxes
//   - ex_rec_t / mem_rec_t / wb_rec_t : shadow records of the EX, MEM and WB
//     instructions, sized by PKG_REG_AW (register-index width)
//   - stage_hits() : "this stage produces register r" test
package forward_ctrl_pkg;

    localparam int unsigned PKG_REG_AW = 5;

    localparam logic [1:0] FWD_REG   = 2'b00;  // register file
    localparam logic [1:0] FWD_EXMEM = 2'b01;  // EX/MEM ALU result
    localparam logic [1:0] FWD_MEMWB = 2'b10;  // MEM/WB write-back data

    typedef logic [PKG_REG_AW-1:0] reg_idx_t;

    typedef struct packed {
        logic     valid;
        reg_idx_t rs;
        reg_idx_t rt;
        reg_idx_t rd;
        logic     regwrite;
        logic     memread;
    } ex_rec_t;

    typedef struct packed {
        logic     valid;
        reg_idx_t rd;
        logic     regwrite;
        logic     memread;
    } mem_rec_t;

    typedef struct packed {
        logic     valid;
        reg_idx_t rd;
        logic     regwrite;
    } wb_rec_t;

    // Register 0 is hard-wired, so a write to it never produces a value.
    function automatic logic stage_hits(input logic     valid,
                                        input logic     regwrite,
                                        input reg_idx_t rd,
                                        input reg_idx_t r);
        return valid & regwrite & (rd != '0) & (rd == r);
    endfunction

endpackage

// File: rtl/forward_ctrl_fwd_select.sv
// fwd_select
//   Priority comparator producing one EX operand mux select.
//   Ports:
//     operand : source register index read by the EX instruction
//     mem_rec : shadow record of the MEM-stage instruction
//     wb_rec  : shadow record of the WB-stage instruction
//     sel     : FWD_EXMEM if MEM produces operand, else FWD_MEMWB if WB
//               does, else FWD_REG (2'b11 is never produced)
module fwd_select
    import forward_ctrl_pkg::*;
(
    input  reg_idx_t   operand,
    input  mem_rec_t   mem_rec,
    input  wb_rec_t    wb_rec,
    output logic [1:0] sel
);

    // MEM is checked first: it holds the younger, more recent value.
    always_comb begin
        sel = FWD_REG;
        if (stage_hits(mem_rec.valid, mem_rec.regwrite, mem_rec.rd, operand)) begin
            sel = FWD_EXMEM;
        end else if (stage_hits(wb_rec.valid, wb_rec.regwrite, wb_rec.rd, operand)) begin
            sel = FWD_MEMWB;
        end
    end

endmodule

// File: rtl/forward_ctrl.sv
// forward_ctrl
//   Forwarding and load-use hazard controller for the 5-stage pipeline.
//   Shadows the EX/MEM/WB destination fields, drives the EX operand mux
//   selects and stalls the front end for one cycle on a load-use hazard.
//   Ports:
//     clk_i, rst_i       : clock (rising edge), async active-high reset
//     id_valid_i         : ID stage holds a real instruction
//     id_rs_i, id_rt_i   : ID source registers
//     id_rd_i            : ID destination register (already muxed rd/rt)
//     id_regwrite_i      : ID instruction writes the register file
//     id_memread_i       : ID instruction is a load
//     flush_i            : kill the ID instruction (taken branch/jump)
//     fwd_a_o, fwd_b_o   : EX operand A/B mux selects
//     stall_o            : hold PC and IF/ID this cycle
//     stall_cnt_o        : saturating count of stall cycles
module forward_ctrl
    import forward_ctrl_pkg::*;
#(
    parameter int unsigned REG_AW = PKG_REG_AW,  // must match PKG_REG_AW
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              id_valid_i,
    input  logic [REG_AW-1:0] id_rs_i,
    input  logic [REG_AW-1:0] id_rt_i,
    input  logic [REG_AW-1:0] id_rd_i,
    input  logic              id_regwrite_i,
    input  logic              id_memread_i,
    input  logic              flush_i,
    output logic [1:0]        fwd_a_o,
    output logic [1:0]        fwd_b_o,
    output logic              stall_o,
    output logic [CNT_W-1:0]  stall_cnt_o
);

    ex_rec_t          ex_q;
    mem_rec_t         mem_q;
    wb_rec_t          wb_q;
    logic [CNT_W-1:0] stall_cnt_q;
    logic             load_use;
    logic             id_enter;

    // Both rs and rt are compared whatever the format; an occasional
    // spurious stall is cheaper than decoding which operands are real.
    assign load_use = ex_q.valid & ex_q.memread & (ex_q.rd != '0) &
                      ((ex_q.rd == id_rs_i) | (ex_q.rd == id_rt_i));

    // Flush overrides load-use: the killed instruction needs no stall.
    assign stall_o  = id_valid_i & ~flush_i & load_use;
    assign id_enter = id_valid_i & ~flush_i & ~stall_o;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ex_q        <= '0;
            mem_q       <= '0;
            wb_q        <= '0;
            stall_cnt_q <= '0;
        end else begin
            wb_q.valid     <= mem_q.valid;
            wb_q.rd        <= mem_q.rd;
            wb_q.regwrite  <= mem_q.regwrite;

            mem_q.valid    <= ex_q.valid;
            mem_q.rd       <= ex_q.rd;
            mem_q.regwrite <= ex_q.regwrite;
            mem_q.memread  <= ex_q.memread;

            if (id_enter) begin
                ex_q.valid    <= 1'b1;
                ex_q.rs       <= id_rs_i;
                ex_q.rt       <= id_rt_i;
                ex_q.rd       <= id_rd_i;
                ex_q.regwrite <= id_regwrite_i;
                ex_q.memread  <= id_memread_i;
            end else begin
                ex_q <= '0;
            end

            if (stall_o && (stall_cnt_q != '1)) begin
                stall_cnt_q <= stall_cnt_q + CNT_W'(1);
            end
        end
    end

    assign stall_cnt_o = stall_cnt_q;

    fwd_select u_fwd_a (
        .operand (ex_q.rs),
        .mem_rec (mem_q),
        .wb_rec  (wb_q),
        .sel     (fwd_a_o)
    );

    fwd_select u_fwd_b (
        .operand (ex_q.rt),
        .mem_rec (mem_q),
        .wb_rec  (wb_q),
        .sel     (fwd_b_o)
    );

endmodule

// File: tb/tb_forward_ctrl.sv
// tb_forward_ctrl
//   Directed scenarios plus randomized traffic for forward_ctrl, checked
//   against an instruction-level pipeline model (a three-slot array of
//   instructions; the select is the distance to the nearest older producer).
module tb_forward_ctrl;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        id_valid_i;
    logic [4:0]  id_rs_i, id_rt_i, id_rd_i;
    logic        id_regwrite_i, id_memread_i, flush_i;
    logic [1:0]  fwd_a_o, fwd_b_o;
    logic        stall_o;
    logic [15:0] stall_cnt_o;

    always #5 clk = ~clk;

    forward_ctrl #(.REG_AW(5), .CNT_W(16)) dut (
        .clk_i         (clk),
        .rst_i         (rst_i),
        .id_valid_i    (id_valid_i),
        .id_rs_i       (id_rs_i),
        .id_rt_i       (id_rt_i),
        .id_rd_i       (id_rd_i),
        .id_regwrite_i (id_regwrite_i),
        .id_memread_i  (id_memread_i),
        .flush_i       (flush_i),
        .fwd_a_o       (fwd_a_o),
        .fwd_b_o       (fwd_b_o),
        .stall_o       (stall_o),
        .stall_cnt_o   (stall_cnt_o)
    );

    typedef struct {
        bit v;
        int rs;
        int rt;
        int rd;
        bit rw;
        bit mr;
    } ins_t;

    ins_t pipe [3];      // 0 = EX, 1 = MEM, 2 = WB
    ins_t cur;
    ins_t empty_ins;
    bit   cur_fl;
    bit   exp_stall;
    int   cnt_m;
    int   vectors;
    int   miscompares;
    int   cnt_save;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Distance (1 = MEM, 2 = WB) to the nearest older instruction producing r.
    function automatic int exp_sel(input int r);
        for (int d = 1; d <= 2; d++) begin
            if (pipe[d].v && pipe[d].rw && pipe[d].rd != 0 && pipe[d].rd == r)
                return d;
        end
        return 0;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 3; i++) pipe[i] = empty_ins;
        cnt_m = 0;
    endtask

    // Present an ID instruction and check the same-cycle outputs.
    task automatic drive(input bit v, input int rs, input int rt, input int rd,
                         input bit rw, input bit mr, input bit fl);
        cur.v = v; cur.rs = rs; cur.rt = rt; cur.rd = rd; cur.rw = rw; cur.mr = mr;
        cur_fl = fl;
        id_valid_i    = v;
        id_rs_i       = 5'(rs);
        id_rt_i       = 5'(rt);
        id_rd_i       = 5'(rd);
        id_regwrite_i = rw;
        id_memread_i  = mr;
        flush_i       = fl;
        #2;
        exp_stall = v && !fl && pipe[0].v && pipe[0].mr && pipe[0].rd != 0 &&
                    (pipe[0].rd == rs || pipe[0].rd == rt);
        chk("fwd_a", 32'(fwd_a_o), 32'(exp_sel(pipe[0].rs)));
        chk("fwd_b", 32'(fwd_b_o), 32'(exp_sel(pipe[0].rt)));
        chk("stall", 32'(stall_o), 32'(exp_stall));
        chk("stall_cnt", 32'(stall_cnt_o), 32'(cnt_m));
    endtask

    task automatic tick();
        @(posedge clk);
        pipe[2] = pipe[1];
        pipe[1] = pipe[0];
        pipe[0] = (cur.v && !cur_fl && !exp_stall) ? cur : empty_ins;
        if (exp_stall && cnt_m != 65535) cnt_m++;
        @(negedge clk);
    endtask

    task automatic nop();
        drive(0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        vectors = 0; miscompares = 0;
        empty_ins = '{v: 0, rs: 0, rt: 0, rd: 0, rw: 0, mr: 0};
        cur = empty_ins;
        exp_stall = 0;
        model_reset();
        rst_i = 1'b1;
        id_valid_i = 0; id_rs_i = 0; id_rt_i = 0; id_rd_i = 0;
        id_regwrite_i = 0; id_memread_i = 0; flush_i = 0;
        #1;
        chk("rst_fwd_a", 32'(fwd_a_o), 0);
        chk("rst_fwd_b", 32'(fwd_b_o), 0);
        chk("rst_stall", 32'(stall_o), 0);
        chk("rst_cnt", 32'(stall_cnt_o), 0);
        @(negedge clk);
        rst_i = 1'b0;

        // Back-to-back ALU dependency, then with one independent gap.
        drive(1, 1, 2, 3, 1, 0, 0); tick();
        drive(1, 3, 4, 7, 1, 0, 0); tick();
        nop(); chk("b2b_alu_a", 32'(fwd_a_o), 1); tick();
        drive(1, 1, 2, 3, 1, 0, 0); tick();
        drive(1, 8, 9, 10, 1, 0, 0); tick();
        drive(1, 3, 4, 7, 1, 0, 0); tick();
        nop(); chk("gap_alu_a", 32'(fwd_a_o), 2); tick();

        // Double hit on r5: MEM wins.
        drive(1, 1, 1, 5, 1, 0, 0); tick();
        drive(1, 2, 2, 5, 1, 0, 0); tick();
        drive(1, 1, 5, 0, 0, 0, 0); tick();
        nop(); chk("double_hit_b", 32'(fwd_b_o), 1); tick();

        // Load-use: one stall cycle, bubble, then WB forwarding.
        drive(1, 1, 0, 4, 1, 1, 0); tick();
        drive(1, 4, 1, 6, 1, 0, 0); chk("lu_stall", 32'(stall_o), 1); tick();
        drive(1, 4, 1, 6, 1, 0, 0); chk("lu_stall_once", 32'(stall_o), 0);
        chk("lu_cnt", 32'(stall_cnt_o), 1); tick();
        nop(); chk("lu_fwd_a", 32'(fwd_a_o), 2); tick();

        // Register 0: loads and ALU writes to r0 never stall or forward.
        drive(1, 1, 1, 0, 1, 1, 0); tick();
        drive(1, 0, 0, 8, 1, 0, 0); chk("r0_load_stall", 32'(stall_o), 0); tick();
        nop(); chk("r0_fwd_a", 32'(fwd_a_o), 0); chk("r0_fwd_b", 32'(fwd_b_o), 0); tick();
        drive(1, 1, 1, 0, 1, 0, 0); tick();
        drive(1, 0, 0, 8, 1, 0, 0); tick();
        nop(); chk("r0_alu_fwd_a", 32'(fwd_a_o), 0); chk("r0_alu_fwd_b", 32'(fwd_b_o), 0); tick();

        // Flush with simultaneous load-use.
        cnt_save = cnt_m;
        drive(1, 1, 0, 4, 1, 1, 0); tick();
        drive(1, 4, 4, 6, 1, 0, 1); chk("flush_stall", 32'(stall_o), 0); tick();
        drive(1, 4, 4, 6, 1, 0, 0); chk("flush_bubble_stall", 32'(stall_o), 0);
        chk("flush_cnt", 32'(stall_cnt_o), 32'(cnt_save)); tick();
        nop(); tick();

        // Reset mid-pipeline with EX/MEM/WB all valid writers.
        drive(1, 0, 0, 1, 1, 0, 0); tick();
        drive(1, 0, 0, 2, 1, 0, 0); tick();
        drive(1, 2, 1, 3, 1, 1, 0); tick();
        drive(1, 3, 0, 9, 1, 0, 0);
        chk("pre_rst_fwd_a", 32'(fwd_a_o), 1);
        chk("pre_rst_fwd_b", 32'(fwd_b_o), 2);
        chk("pre_rst_stall", 32'(stall_o), 1);
        rst_i = 1'b1;
        #1;
        model_reset();
        chk("mid_rst_fwd_a", 32'(fwd_a_o), 0);
        chk("mid_rst_fwd_b", 32'(fwd_b_o), 0);
        chk("mid_rst_stall", 32'(stall_o), 0);
        chk("mid_rst_cnt", 32'(stall_cnt_o), 0);
        @(posedge clk);
        @(negedge clk);
        rst_i = 1'b0;
        drive(1, 1, 2, 9, 1, 0, 0); tick();
        nop(); chk("post_rst_fwd_a", 32'(fwd_a_o), 0);
        chk("post_rst_fwd_b", 32'(fwd_b_o), 0); tick();

        // Randomized traffic over a small register range to provoke hazards.
        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(0, 9) < 8,
                  int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                  int'($urandom_range(0, 7)),
                  $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
                  $urandom_range(0, 9) == 0);
            tick();
        end
        nop();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
